mem_port_arbiter: RTL

Shares the single synchronous memory port of the multicycle RISC-V core between the instruction-fetch path and the load/store path. Each requester uses a req/gnt handshake and gets a one-cycle read-data-valid pulse. The block sits between the control unit's fetch and memory-access stages and the unified instruction/data memory. It keeps at most one read outstanding and issues writes in a single cycle.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arb_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_arbiter_pkg;

    // Which requester owns the outstanding read (or last won a grant).
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Largest supported memory read latency; sizes the wait counter.
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 2;

endpackage

// File: rtl/mem_port_arb_pick.sv
// Winner selection between fetch and load/store requests (MEM_ARB_RR_EN: round-robin on ties).
// Latency: purely combinational, same cycle.
// Backpressure: the loser is simply not picked and keeps requesting.
module mem_port_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_winner,
`endif
    output logic   pick_if,
    output logic   pick_ls
);

    // Uncontested requests win outright; ties go by mode.
    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
            // The side that did not win last time gets the port.
            if (last_winner == OWN_LS) begin
                pick_if = 1'b1;
            end else begin
                pick_ls = 1'b1;
            end
`else
            // Fixed priority: load/store beats fetch.
            pick_ls = 1'b1;
`endif
        end else begin
            pick_if = if_req;
            pick_ls = ls_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch and load/store (MEM_ARB_RR_EN selects round-robin ties).
// Latency: gnt same cycle; read data valid RD_LAT cycles after grant; stores complete in the grant cycle.
// Backpressure: one read outstanding; requests are ignored (no gnt) while a read is in flight.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Reject unsupported latencies at elaboration.
    generate
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("mem_port_arbiter: RD_LAT must be in 1..%0d", RD_LAT_MAX);
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             pick_if;
    logic             pick_ls;
    logic             can_grant;
    logic             rd_grant;

`ifdef MEM_ARB_RR_EN
    owner_t           last_winner;
`endif

    mem_port_arb_pick u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
`ifdef MEM_ARB_RR_EN
        .last_winner (last_winner),
`endif
        .pick_if     (pick_if),
        .pick_ls     (pick_ls)
    );

    // Grants only from IDLE and never while reset is held.
    assign can_grant = rst_n && (state == ST_IDLE);
    assign if_gnt    = can_grant && pick_if;
    assign ls_gnt    = can_grant && pick_ls;
    assign rd_grant  = if_gnt || (ls_gnt && !ls_we);

    // Memory port follows the winner; idle port is driven to zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_we    = ls_we;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Read data is a pass-through; the rvalid pulses qualify it.
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;
    assign busy      = (state == ST_WAIT);
    assign if_rvalid = busy && (cnt == '0) && (owner == OWN_IF);
    assign ls_rvalid = busy && (cnt == '0) && (owner == OWN_LS);

    // Read-tracking FSM: latch owner on a read grant, count down, release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_grant) begin
                        state <= ST_WAIT;
                        owner <= if_gnt ? OWN_IF : OWN_LS;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who won the most recent grant, contested or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= OWN_IF;
        end else if (if_gnt) begin
            last_winner <= OWN_IF;
        end else if (ls_gnt) begin
            last_winner <= OWN_LS;
        end
    end
`endif

endmodule
